// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line settings
// common to the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } uart_state_t;

   localparam int CLK_HZ_DEF = 70_000_000;
   localparam int BAUD_DEF   = 115_200;

endpackage

// File: rtl/uart_baud_tick.sv
// Phase-accumulator tick generator: one-clock pulses at an average rate of RATE
// per second from a CLK_HZ clock. Shared by the UART transmitter and receiver.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int RATE   = BAUD_DEF * 16,
   parameter int ACC_W  = 29
) (
   input  logic sys_clk_i,
   input  logic sys_rst_i,
   output logic tick_o
);

   localparam logic [ACC_W-1:0] INC_WAIT = ACC_W'(RATE);
   localparam logic [ACC_W-1:0] INC_TICK = ACC_W'(RATE - CLK_HZ);

   logic [ACC_W-1:0] r_acc;

   // A non-negative accumulator emits a tick and pays back CLK_HZ.
   always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_acc <= '0;
      end else if (r_acc[ACC_W-1]) begin
         r_acc <= r_acc + INC_WAIT;
      end else begin
         r_acc <= r_acc + INC_TICK;
      end
   end

   assign tick_o = ~r_acc[ACC_W-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start validation, LSB-first byte assembly and a
// holding register with ready/read handshake, overrun and framing-error flags.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits at mid-bit
// STOP  | sampling stop bit; high loads the byte, low flags framing error
// BRK   | line held low after framing error, waiting for it to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int BAUD   = BAUD_DEF,
   parameter int OS     = 16,
   parameter int ACC_W  = 29
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   input  logic       uart_rx_i,
   input  logic       uart_rd_i,
   output logic [7:0] uart_dat_o,
   output logic       uart_rdy_o,
   output logic       uart_ovr_o,
   output logic       uart_ferr_o
);

   localparam int SC_W = $clog2(OS);
   localparam logic [SC_W-1:0] SC_MID = SC_W'(OS / 2 - 1);
   localparam logic [SC_W-1:0] SC_END = SC_W'(OS - 1);

   logic [1:0]      r_sync;
   uart_state_t     r_state;
   logic [SC_W-1:0] r_scnt;
   logic [2:0]      r_bidx;
   logic [7:0]      r_shift;
   logic [7:0]      r_dat;
   logic            r_rdy;
   logic            r_ovr;
   logic            r_ferr;

   uart_state_t     w_state_nxt;
   logic [SC_W-1:0] w_scnt_nxt;
   logic [2:0]      w_bidx_nxt;
   logic [7:0]      w_shift_nxt;
   logic            w_load;
   logic            w_ferr;
   logic            w_tick;
   logic            w_rxs;

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ),
      .RATE   (BAUD * OS),
      .ACC_W  (ACC_W)
   ) u_tick (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .tick_o    (w_tick)
   );

   assign w_rxs = r_sync[1];

   always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_sync  <= 2'b11;
         r_state <= IDLE;
         r_scnt  <= '0;
         r_bidx  <= '0;
         r_shift <= '0;
      end else begin
         r_sync  <= {r_sync[0], uart_rx_i};
         r_state <= w_state_nxt;
         r_scnt  <= w_scnt_nxt;
         r_bidx  <= w_bidx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_scnt_nxt  = r_scnt;
      w_bidx_nxt  = r_bidx;
      w_shift_nxt = r_shift;
      w_load      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = START;
               w_scnt_nxt  = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_scnt == SC_MID) begin
                  w_scnt_nxt = '0;
                  w_bidx_nxt = '0;
                  w_state_nxt = w_rxs ? IDLE : DATA;
               end else begin
                  w_scnt_nxt = r_scnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_scnt == SC_END) begin
                  w_scnt_nxt  = '0;
                  w_shift_nxt = {w_rxs, r_shift[7:1]};
                  w_bidx_nxt  = r_bidx + 1'b1;
                  if (r_bidx == 3'd7) begin
                     w_state_nxt = STOP;
                  end
               end else begin
                  w_scnt_nxt = r_scnt + 1'b1;
               end
            end
         end
         STOP: begin
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (w_tick) begin
               if (r_scnt == SC_END) begin
                  w_scnt_nxt = '0;
                  if (w_rxs) begin
                     w_load      = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_ferr      = 1'b1;
                     w_state_nxt = BRK;
                  end
               end else begin
                  w_scnt_nxt = r_scnt + 1'b1;
               end
            end
         end
         BRK: begin
            if (w_rxs) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // A load always wins over a read; a read in the same cycle only clears overrun.
   always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_dat  <= '0;
         r_rdy  <= 1'b0;
         r_ovr  <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (w_load) begin
            r_dat <= r_shift;
            r_rdy <= 1'b1;
            if (r_rdy) begin
               r_ovr <= ~uart_rd_i;
            end
         end else if (uart_rd_i && r_rdy) begin
            r_rdy <= 1'b0;
            r_ovr <= 1'b0;
         end
      end
   end

   assign uart_dat_o  = r_dat;
   assign uart_rdy_o  = r_rdy;
   assign uart_ovr_o  = r_ovr;
   assign uart_ferr_o = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. The line rate is raised to 460800 so the whole
// sequence stays short; all bit-time ratios match the 115200 plan.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CLK_HZ   = 70_000_000;
   localparam int BAUD     = 460_800;
   localparam int BIT_CLKS = CLK_HZ / BAUD;
   localparam int FRM_CLKS = 10 * CLK_HZ / BAUD;

   typedef struct packed {
      logic [7:0] dat;
      logic       ovr;
   } exp_t;

   logic       sys_clk_i = 1'b0;
   logic       sys_rst_i = 1'b1;
   logic       uart_rx_i = 1'b1;
   logic       uart_rd_i;
   logic [7:0] uart_dat_o;
   logic       uart_rdy_o;
   logic       uart_ovr_o;
   logic       uart_ferr_o;

   logic       rd_man  = 1'b0;
   logic       rd_auto = 1'b0;
   bit         autord  = 1'b0;
   bit         hit;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         ferr_cnt = 0;
   int         lat;
   exp_t       q[$];
   logic       prev_rdy = 1'b0;
   logic [7:0] prev_dat = 8'h00;

   assign uart_rd_i = rd_man | rd_auto;

   always #7 sys_clk_i = ~sys_clk_i;

   uart_rx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD),
      .OS     (16),
      .ACC_W  (29)
   ) dut (
      .sys_clk_i   (sys_clk_i),
      .sys_rst_i   (sys_rst_i),
      .uart_rx_i   (uart_rx_i),
      .uart_rd_i   (uart_rd_i),
      .uart_dat_o  (uart_dat_o),
      .uart_rdy_o  (uart_rdy_o),
      .uart_ovr_o  (uart_ovr_o),
      .uart_ferr_o (uart_ferr_o)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic o);
      exp_t e;
      e.dat = d;
      e.ovr = o;
      q.push_back(e);
   endtask

   // Drives frame bits LSB first; bit boundaries follow the exact sender rate.
   task automatic send_bits(input logic [9:0] f, input int nbits, input int baud);
      longint t_a;
      longint t_b;
      for (int k = 0; k < nbits; k++) begin
         uart_rx_i = f[k];
         t_a = (longint'(k) * CLK_HZ) / baud;
         t_b = (longint'(k + 1) * CLK_HZ) / baud;
         repeat (int'(t_b - t_a)) @(posedge sys_clk_i);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int baud, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      send_bits(f, 10, baud);
   endtask

   task automatic wait_drain(input string name, input int max_clks);
      for (int i = 0; i < max_clks && q.size() != 0; i++) @(posedge sys_clk_i);
      repeat (2) @(posedge sys_clk_i);
      check(name, q.size(), 0);
   endtask

   initial forever begin
      @(posedge sys_clk_i);
      rd_auto = autord && uart_rdy_o && !rd_auto;
   end

   always @(posedge sys_clk_i) begin : mon
      exp_t e;
      if (sys_rst_i) begin
         prev_rdy <= 1'b0;
         prev_dat <= 8'h00;
      end else begin
         if (uart_ferr_o) ferr_cnt++;
         if (uart_rdy_o && (!prev_rdy || uart_dat_o != prev_dat)) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%02h, expected no byte", uart_dat_o);
            end else begin
               e = q.pop_front();
               check("rx_byte", int'(uart_dat_o), int'(e.dat));
               check("rx_ovr", int'(uart_ovr_o), int'(e.ovr));
            end
         end
         prev_rdy <= uart_rdy_o;
         prev_dat <= uart_dat_o;
      end
   end

   initial begin
      logic [7:0] tol_bytes [3];
      int         tol_baud [2];
      tol_bytes = '{8'h00, 8'hFF, 8'h55};
      tol_baud  = '{446_976, 474_624};

      repeat (5) @(posedge sys_clk_i);
      check("reset_dat", int'(uart_dat_o), 0);
      check("reset_rdy", int'(uart_rdy_o), 0);
      check("reset_ovr", int'(uart_ovr_o), 0);
      check("reset_ferr", int'(uart_ferr_o), 0);
      sys_rst_i = 1'b0;
      repeat (20) @(posedge sys_clk_i);

      // Basic byte plus start-edge-to-ready latency (9.5 bits = 1443 clocks).
      autord = 1'b1;
      expect_byte(8'hA5, 1'b0);
      lat = 0;
      fork
         send_frame(8'hA5, BAUD, 1'b1);
         begin
            while (!uart_rdy_o && lat < 4000) begin
               @(posedge sys_clk_i);
               lat++;
            end
         end
      join
      n_tests++;
      if (lat < 1425 || lat > 1465) begin
         n_fail++;
         $display("FAIL rdy_latency: got %0d clocks, expected 1425..1465", lat);
      end
      wait_drain("drain_a5", 400);
      check("a5_no_ferr", ferr_cnt, 0);

      // Glitch shorter than half a bit must not start a frame.
      uart_rx_i = 1'b0;
      repeat (BIT_CLKS / 3) @(posedge sys_clk_i);
      uart_rx_i = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge sys_clk_i);
      check("glitch_rdy", int'(uart_rdy_o), 0);
      expect_byte(8'h3C, 1'b0);
      send_frame(8'h3C, BAUD, 1'b1);
      wait_drain("drain_3c", 400);
      check("glitch_no_ferr", ferr_cnt, 0);

      // Low stop bit followed by a break of three frame times.
      send_frame(8'h81, BAUD, 1'b0);
      repeat (3 * FRM_CLKS) @(posedge sys_clk_i);
      uart_rx_i = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge sys_clk_i);
      check("break_ferr_count", ferr_cnt, 1);
      check("break_rdy", int'(uart_rdy_o), 0);
      expect_byte(8'h42, 1'b0);
      send_frame(8'h42, BAUD, 1'b1);
      wait_drain("drain_42", 400);

      // Overrun, explicit read, then read on the exact load cycle.
      autord = 1'b0;
      repeat (10) @(posedge sys_clk_i);
      expect_byte(8'h11, 1'b0);
      send_frame(8'h11, BAUD, 1'b1);
      expect_byte(8'h22, 1'b1);
      send_frame(8'h22, BAUD, 1'b1);
      wait_drain("drain_ovr", 400);
      check("ovr_dat", int'(uart_dat_o), 8'h22);
      check("ovr_rdy", int'(uart_rdy_o), 1);
      check("ovr_flag", int'(uart_ovr_o), 1);
      rd_man = 1'b1;
      @(posedge sys_clk_i);
      rd_man = 1'b0;
      check("read_rdy", int'(uart_rdy_o), 0);
      check("read_ovr", int'(uart_ovr_o), 0);
      expect_byte(8'h44, 1'b0);
      send_frame(8'h44, BAUD, 1'b1);
      wait_drain("drain_44", 400);
      expect_byte(8'h33, 1'b0);
      hit = 1'b0;
      fork
         send_frame(8'h33, BAUD, 1'b1);
         begin
            for (int i = 0; i < 3000 && !hit; i++) begin
               @(posedge sys_clk_i);
               if (dut.w_load) begin
                  rd_man = 1'b1;
                  @(posedge sys_clk_i);
                  rd_man = 1'b0;
                  hit = 1'b1;
               end
            end
         end
      join
      check("rd_load_seen", int'(hit), 1);
      check("rd_load_rdy", int'(uart_rdy_o), 1);
      check("rd_load_dat", int'(uart_dat_o), 8'h33);
      check("rd_load_ovr", int'(uart_ovr_o), 0);
      wait_drain("drain_33", 400);

      // Reset in the middle of data bit 4 of 0x5A.
      send_bits({1'b1, 8'h5A, 1'b0}, 5, BAUD);
      uart_rx_i = 1'b1;
      repeat (BIT_CLKS / 2) @(posedge sys_clk_i);
      sys_rst_i = 1'b1;
      #1;
      check("midrst_dat", int'(uart_dat_o), 0);
      check("midrst_rdy", int'(uart_rdy_o), 0);
      check("midrst_ovr", int'(uart_ovr_o), 0);
      check("midrst_ferr", int'(uart_ferr_o), 0);
      repeat (5) @(posedge sys_clk_i);
      sys_rst_i = 1'b0;
      repeat (2 * BIT_CLKS) @(posedge sys_clk_i);
      check("midrst_no_byte", int'(uart_rdy_o), 0);
      expect_byte(8'h5A, 1'b0);
      send_frame(8'h5A, BAUD, 1'b1);
      wait_drain("drain_5a", 400);

      // Back-to-back streams with the sender 3% slow and 3% fast.
      autord = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int b = 0; b < 3; b++) begin
            expect_byte(tol_bytes[b], 1'b0);
            send_frame(tol_bytes[b], tol_baud[r], 1'b1);
         end
         wait_drain("drain_tol", 400);
         repeat (BIT_CLKS) @(posedge sys_clk_i);
      end
      check("final_ferr_count", ferr_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the UART transmit block: 8N1 frames, LSB first, idle-high.
- Oversamples the asynchronous RX pin with a phase-accumulator tick and validates the start bit at mid-bit.
- Assembles each byte and presents it in a holding register with a ready/read handshake toward the processor I/O bus.
- Flags framing errors and overruns.

Parameters:
- CLK_HZ, 70_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OS, 16, oversample ticks per bit. Power of two, at least 8.
- ACC_W, 29, phase accumulator width. Must hold CLK_HZ as a signed value.

Ports:
- sys_clk_i  in  1  system clock. All registers update on its falling edge.
- sys_rst_i  in  1  reset, asynchronous, active-high.
- uart_rx_i  in  1  serial input, asynchronous to sys_clk_i, idle high.
- uart_rd_i  in  1  read strobe. Consumes the held byte.
- uart_dat_o  out  8  held received byte.
- uart_rdy_o  out  1  high while an unread byte is held.
- uart_ovr_o  out  1  sticky overrun flag.
- uart_ferr_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values:
  - uart_dat_o = 0x00, uart_rdy_o = 0, uart_ovr_o = 0, uart_ferr_o = 0.
  - Synchroniser flops = 1, accumulator = 0, state = IDLE.
  - Reset mid-frame discards the partial byte and returns to IDLE immediately.
- Synchroniser: two flops on uart_rx_i. All decisions use the second flop (rxs). Input-to-decision latency is 2 clocks.
- Tick generator, free-running from reset:
  - If acc[ACC_W-1] = 1, then acc += BAUD*OS and tick = 0.
  - Otherwise acc += BAUD*OS - CLK_HZ and tick = 1.
  - Average tick rate is BAUD*OS; tick is a one-clock pulse.
- State machine. scnt is a 4-bit tick counter; bidx is a 3-bit bit index.
  - IDLE: rxs = 0 → START, scnt = 0.
  - START: on tick, scnt++. When scnt reaches OS/2-1 (mid start bit), sample rxs. If rxs = 1, treat as a glitch and go to IDLE. If rxs = 0, go to DATA with scnt = 0 and bidx = 0.
  - DATA: on tick, scnt++. At scnt = OS-1 (mid-bit), shift rxs into shifter[7] (right shift, so LSB arrives first) and set bidx++. After bidx = 7 is sampled → STOP.
  - STOP: at scnt = OS-1, sample rxs.
    - rxs = 1: load uart_dat_o ← shifter and set uart_rdy_o = 1, then → IDLE. Leaving at mid-stop allows back-to-back frames.
    - rxs = 0: pulse uart_ferr_o for one clock, load nothing, then → BRK.
  - BRK: wait for rxs = 1, then → IDLE. A held-low line (break) produces exactly one ferr and no bytes.
- Handshake:
  - uart_rd_i with uart_rdy_o = 1 clears uart_rdy_o and uart_ovr_o on the next edge.
  - uart_rd_i with uart_rdy_o = 0 has no effect.
- Overrun: a load while uart_rdy_o = 1 and uart_rd_i = 0 overwrites uart_dat_o with the new byte and sets uart_ovr_o. uart_rdy_o stays 1.
- Simultaneous load and uart_rd_i: the load wins. uart_rdy_o stays 1, uart_dat_o takes the new byte, uart_ovr_o is cleared (the old byte was read).
- Latency: uart_rdy_o rises about 9.5 bit periods after the start edge, ±1 tick, +2 clocks.
- Tolerance: correct reception for a sender baud error of ±3%.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding: IDLE, START, DATA, STOP, BRK.
  - Default CLK_HZ and BAUD constants, shared with the transmit side.
- One sub-module, uart_baud_tick, holds the phase-accumulator tick generator (parameters CLK_HZ, RATE, ACC_W; output tick). It is reusable by the transmitter.

Test Plan:
- Byte reception: drive 0xA5 at 115200 (607.6 clocks/bit) → uart_rdy_o rises about 5770 clocks after the start edge, uart_dat_o = 0xA5, ferr = 0.
- Glitch rejection: 200-clock low pulse on idle line → no state leaves START, rdy = 0. A following 0x3C is still received correctly.
- Framing error and break: frame 0x81 with stop bit = 0 and line held low 3 frame times → exactly one ferr pulse, rdy = 0, no byte. Then line high followed by 0x42 → dat = 0x42.
- Overrun and handshake:
  - Send 0x11 then 0x22 without reading → dat = 0x22, rdy = 1, ovr = 1.
  - Pulse uart_rd_i → rdy = 0, ovr = 0.
  - Assert rd on the exact load clock of 0x33 → rdy = 1, dat = 0x33, ovr = 0.
- Baud tolerance: stream 0x00, 0xFF, 0x55 back-to-back at sender rates 111744 and 118656 (±3%) → all three bytes correct, no ferr.
- Reset mid-frame: assert sys_rst_i during bit 4 of 0x5A → all outputs reset immediately. After release, a fresh 0x5A is received correctly with no spurious byte.
